// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader: timed HD44780 read cycles (busy flag or data) with optional busy-poll and bus request/grant
// Ports: iCLK/iRST_N clock and async active-low reset; iStart/iRS/iPoll command (latched in IDLE);
// oBUS_REQ/iBUS_GNT bus handshake; LCD_DATA read bus; oLCD_RW/oLCD_EN/oLCD_RS registered strobes;
// oData/oBF last sample and busy flag; oDone/oErr completion pulse and status; oBusy not idle.
module lcd_bus_reader #(
  parameter int T_AS      = 3,
  parameter int T_PW      = 12,
  parameter int T_H       = 2,
  parameter int T_GAP     = 8,
  parameter int MAX_POLLS = 255
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  output logic       oBUS_REQ,
  input  logic       iBUS_GNT,
  input  logic [7:0] LCD_DATA,
  output logic       oLCD_RW,
  output logic       oLCD_EN,
  output logic       oLCD_RS,
  output logic [7:0] oData,
  output logic       oBF,
  output logic       oDone,
  output logic       oErr,
  output logic       oBusy
);
  typedef enum logic [2:0] {IDLE, REQ, SETUP, EN_HI, HOLD, GAP, DONE} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, pcnt, pcnt_n, data, data_n;
  logic req, req_n, rw, rw_n, en, en_n, rs, rs_n, bf, bf_n, done, done_n, err, err_n, poll, poll_n;
  logic active, last, again;
  assign active = state inside {SETUP, EN_HI, HOLD, GAP};
  assign last = cnt == 8'd0;
  // Poll count never exceeds MAX_POLLS-1, so it cannot wrap.
  assign again = poll && bf && ((9'(pcnt) + 9'd1) < 9'(MAX_POLLS));
  always_comb begin
    state_n = state;
    cnt_n = active ? cnt - 8'd1 : cnt;
    pcnt_n = pcnt;
    data_n = data;
    req_n = req;
    rw_n = rw;
    en_n = en;
    rs_n = rs;
    bf_n = bf;
    done_n = 1'b0;
    err_n = err;
    poll_n = poll;
    case (state)
      IDLE: if (iStart) begin
        state_n = REQ;
        req_n = 1'b1;
        rs_n = iRS;
        poll_n = iPoll & ~iRS;
        pcnt_n = 8'd0;
      end
      REQ: if (iBUS_GNT) begin
        state_n = SETUP;
        rw_n = 1'b1;
        cnt_n = 8'(T_AS - 1);
      end
      SETUP: if (last) begin
        state_n = EN_HI;
        en_n = 1'b1;
        cnt_n = 8'(T_PW - 1);
      end
      EN_HI: if (last) begin
        state_n = HOLD;
        en_n = 1'b0;
        data_n = LCD_DATA;
        bf_n = rs ? bf : LCD_DATA[7];
        cnt_n = 8'(T_H - 1);
      end
      HOLD: if (last) begin
        state_n = GAP;
        rw_n = 1'b0;
        cnt_n = 8'(T_GAP - 1);
      end
      GAP: if (last) begin
        state_n = again ? SETUP : DONE;
        rw_n = again;
        pcnt_n = again ? pcnt + 8'd1 : pcnt;
        cnt_n = again ? 8'(T_AS - 1) : 8'd0;
        req_n = again;
        done_n = ~again;
        err_n = again ? err : poll && bf;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Losing the grant mid-cycle abandons the read with an error.
    if (active && !iBUS_GNT) begin
      state_n = DONE;
      en_n = 1'b0;
      rw_n = 1'b0;
      req_n = 1'b0;
      done_n = 1'b1;
      err_n = 1'b1;
      cnt_n = 8'd0;
    end
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      cnt <= 8'd0;
      pcnt <= 8'd0;
      data <= 8'd0;
      req <= 1'b0;
      rw <= 1'b0;
      en <= 1'b0;
      rs <= 1'b0;
      bf <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      poll <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pcnt <= pcnt_n;
      data <= data_n;
      req <= req_n;
      rw <= rw_n;
      en <= en_n;
      rs <= rs_n;
      bf <= bf_n;
      done <= done_n;
      err <= err_n;
      poll <= poll_n;
    end
  end
  assign oBUS_REQ = req;
  assign oLCD_RW = rw;
  assign oLCD_EN = en;
  assign oLCD_RS = rs;
  assign oData = data;
  assign oBF = bf;
  assign oDone = done;
  assign oErr = err;
  assign oBusy = state != IDLE;
endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb_lcd_bus_reader: table, hand-written and random checks of lcd_bus_reader against a timing model
module tb_lcd_bus_reader;
  localparam int T_AS = 3, T_PW = 12, T_H = 2, T_GAP = 8, MAXP = 4;
  localparam int CYC = T_AS + T_PW + T_H + T_GAP;
  typedef struct {
    logic rs;
    logic poll;
    int d;
    int k;
    logic [7:0] bv;
    logic [7:0] fv;
    int exp_done;
    int exp_reads;
    logic [7:0] exp_data;
    logic exp_bf;
    logic exp_err;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0, rs = 0, poll = 0, gnt = 0;
  logic [7:0] lcd_data, data;
  logic req, rw, en, lrs, bf, done, err, busy;
  int checks = 0, errors = 0;
  int rd_idx = 0, busy_k = 0;
  logic [7:0] bval = 0, fval = 0;
  logic m_bf = 0;
  vec_t vecs [7];
  always #10 clk = ~clk;
  // The LCD answers the first busy_k reads with bval, then fval.
  assign lcd_data = (rd_idx < busy_k) ? bval : fval;
  always @(negedge en) rd_idx = rd_idx + 1;
  lcd_bus_reader #(.T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_GAP(T_GAP), .MAX_POLLS(MAXP)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iRS(rs), .iPoll(poll),
    .oBUS_REQ(req), .iBUS_GNT(gnt), .LCD_DATA(lcd_data),
    .oLCD_RW(rw), .oLCD_EN(en), .oLCD_RS(lrs),
    .oData(data), .oBF(bf), .oDone(done), .oErr(err), .oBusy(busy)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  // Reference: reads stop at the first clear BF or after MAXP reads; each read costs CYC cycles.
  function automatic vec_t model(input logic vrs, input logic vpoll, input int d, input int k,
                                 input logic [7:0] bv, input logic [7:0] fv);
    vec_t v;
    int reads;
    reads = (vpoll && !vrs) ? ((k < MAXP) ? k + 1 : MAXP) : 1;
    v.rs = vrs;
    v.poll = vpoll;
    v.d = d;
    v.k = k;
    v.bv = bv;
    v.fv = fv;
    v.exp_reads = reads;
    v.exp_err = vpoll && !vrs && k >= MAXP;
    v.exp_data = (reads - 1 < k) ? bv : fv;
    v.exp_bf = vrs ? m_bf : v.exp_data[7];
    v.exp_done = 1 + d + reads * CYC;
    return v;
  endfunction
  task automatic run_op(input vec_t v, input string tag);
    int n, done_at, pulses, en_cyc, first_rise, last_rise, bad_space, bad_ctl, limit;
    logic pen, prs, prw;
    busy_k = v.k;
    bval = v.bv;
    fval = v.fv;
    rd_idx = 0;
    gnt = (v.d == 0);
    @(negedge clk);
    start = 1;
    rs = v.rs;
    poll = v.poll;
    @(posedge clk);
    #1;
    start = 0;
    chk({tag, ".req"}, req, 1);
    n = 0;
    done_at = -1;
    pulses = 0;
    en_cyc = 0;
    first_rise = -1;
    last_rise = -1;
    bad_space = 0;
    bad_ctl = 0;
    pen = en;
    prs = lrs;
    prw = rw;
    limit = v.exp_done + 40;
    while (done_at < 0 && n < limit) begin
      if (n == v.d) gnt = 1;
      @(posedge clk);
      #1;
      n++;
      if (en) begin
        en_cyc++;
        if (!rw || lrs != v.rs) bad_ctl++;
        if (!pen) begin
          pulses++;
          if (prs != lrs || prw != rw) bad_ctl++;
          if (first_rise < 0) first_rise = n;
          else if (n - last_rise != CYC) bad_space++;
          last_rise = n;
        end
      end
      if (done) done_at = n;
      pen = en;
      prs = lrs;
      prw = rw;
    end
    chk({tag, ".done_edge"}, done_at, v.exp_done);
    chk({tag, ".en_pulses"}, pulses, v.exp_reads);
    chk({tag, ".en_cycles"}, en_cyc, v.exp_reads * T_PW);
    chk({tag, ".first_rise"}, first_rise, 1 + v.d + T_AS);
    chk({tag, ".ctl_during_en"}, bad_ctl, 0);
    chk({tag, ".spacing"}, bad_space, 0);
    chk({tag, ".err"}, err, v.exp_err);
    chk({tag, ".data"}, data, v.exp_data);
    chk({tag, ".bf"}, bf, v.exp_bf);
    chk({tag, ".req_released"}, req, 0);
    @(posedge clk);
    #1;
    chk({tag, ".done_one_cycle"}, done, 0);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".err_held"}, err, v.exp_err);
    m_bf = v.exp_bf;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, done_at, bad;
    vec_t v;
    vecs[0] = '{1'b0, 1'b0, 0, 0, 8'h00, 8'h85, 26, 1, 8'h85, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 10, 0, 8'h00, 8'h48, 36, 1, 8'h48, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 0, 3, 8'h80, 8'h12, 101, 4, 8'h12, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 0, 10, 8'hFF, 8'hFF, 101, 4, 8'hFF, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 2, 2, 8'h9A, 8'h33, 28, 1, 8'h9A, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 0, 0, 8'h00, 8'h7F, 26, 1, 8'h7F, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 3, 2, 8'hC1, 8'h00, 29, 1, 8'hC1, 1'b1, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req", req, 0);
    chk("rst.en", en, 0);
    chk("rst.rw", rw, 0);
    chk("rst.rs", lrs, 0);
    chk("rst.data", data, 0);
    chk("rst.bf", bf, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    // Reset in the fifth EN-high cycle: strobe and request drop without waiting for a clock.
    gnt = 1;
    busy_k = 0;
    fval = 8'h85;
    rd_idx = 0;
    @(negedge clk);
    start = 1;
    rs = 0;
    poll = 0;
    @(posedge clk);
    #1;
    start = 0;
    repeat (T_AS + 5) @(posedge clk);
    #5;
    chk("midrst.en_before", en, 1);
    rst_n = 0;
    #1;
    chk("midrst.en", en, 0);
    chk("midrst.req", req, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.rw", rw, 0);
    bad = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) bad++;
    end
    chk("midrst.no_done", bad, 0);
    @(negedge clk);
    rst_n = 1;
    m_bf = 0;
    chk("midrst.data", data, 0);
    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));
    // Grant dropped in HOLD; a start pulse while busy must not queue another read.
    gnt = 1;
    busy_k = 0;
    fval = 8'h55;
    rd_idx = 0;
    @(negedge clk);
    start = 1;
    rs = 0;
    poll = 0;
    @(posedge clk);
    #1;
    start = 0;
    n = 0;
    done_at = -1;
    while (n < 40 && done_at < 0) begin
      if (n == 8) start = 1;
      if (n == 9) start = 0;
      if (n == 1 + T_AS + T_PW) gnt = 0;
      @(posedge clk);
      #1;
      n++;
      if (done) done_at = n;
    end
    chk("hold_loss.done_edge", done_at, 2 + T_AS + T_PW);
    chk("hold_loss.err", err, 1);
    chk("hold_loss.data", data, 8'h55);
    chk("hold_loss.bf", bf, 0);
    chk("hold_loss.en", en, 0);
    chk("hold_loss.rw", rw, 0);
    chk("hold_loss.req", req, 0);
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (req || busy || done) bad++;
    end
    chk("hold_loss.no_requeue", bad, 0);
    chk("hold_loss.err_held", err, 1);
    m_bf = 0;
    // Grant dropped in EN_HI before the sample: previous data survives.
    gnt = 1;
    fval = 8'hAA;
    rd_idx = 0;
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    n = 0;
    done_at = -1;
    while (n < 40 && done_at < 0) begin
      if (n == 8) gnt = 0;
      @(posedge clk);
      #1;
      n++;
      if (done) done_at = n;
    end
    chk("en_loss.done_edge", done_at, 9);
    chk("en_loss.en", en, 0);
    chk("en_loss.err", err, 1);
    chk("en_loss.data", data, 8'h55);
    chk("en_loss.bf", bf, 0);
    @(posedge clk);
    for (int i = 0; i < 25; i++) begin
      v = model(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                $urandom_range(0, 6), 8'h80 | 8'($urandom), 8'($urandom) & 8'h7F);
      run_op(v, $sformatf("rnd%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
